// File: rtl/sbox_drv_pkg.sv
// Shared types and constants for the masked Skinny sbox share driver.
// Holds the FSM state encoding, share geometry, the xorshift128 step and
// the plain Skinny sbox table used as a reference by checking benches.
package sbox_drv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, CAPT, DONE} state_t;

  localparam int FRESH_W = 78;
  localparam int SHARES  = 4;
  localparam int NIB_W   = 4;
  localparam int SH_W    = SHARES * NIB_W;

  // Plain 4-bit Skinny sbox, entry i at index i.
  localparam logic [15:0][3:0] SKINNY_SBOX = {
    4'hF, 4'h7, 4'hE, 4'h4, 4'hD, 4'h5, 4'h8, 4'h3,
    4'hB, 4'h2, 4'hA, 4'h1, 4'h0, 4'h9, 4'h6, 4'hC
  };

  // One xorshift128 step; state packed as {x, y, z, w}, x oldest.
  function automatic logic [127:0] xs128_step(input logic [127:0] s);
    logic [31:0] x, y, z, w, t, wn;
    x  = s[127:96];
    y  = s[95:64];
    z  = s[63:32];
    w  = s[31:0];
    t  = x ^ (x << 11);
    wn = w ^ (w >> 19) ^ t ^ (t >> 8);
    return {y, z, w, wn};
  endfunction

endpackage

// File: rtl/sbox_share_driver_d3_prng.sv
// xorshift128 generator: loads the seed while rst is high (zero seed
// forced to 1 so the generator never locks up), then steps every cycle.
module prng_xorshift128
  import sbox_drv_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] seed,
  output logic [127:0] state_o
);

  // Seed on reset, otherwise advance one step per cycle.
  always_ff @(posedge clk) begin
    if (rst) state_o <= (seed == '0) ? 128'h1 : seed;
    else     state_o <= xs128_step(state_o);
  end

endmodule

// File: rtl/sbox_share_driver_d3.sv
// Front end for the 3rd-order HPC2 masked Skinny sbox: splits a nibble
// into 4 Boolean shares, streams fresh randomness, waits for Synch and
// returns the output shares over a valid/ready handshake.
// Build option SBOX_DRV_UNMASK_EN: present the recombined nibble on
// out_data instead of the raw shares on out_sh.
module sbox_share_driver_d3
  import sbox_drv_pkg::*;
#(
  parameter int LATENCY = 11,
  parameter int TIMEOUT = 4,
  parameter int SEED_W  = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEED_W-1:0]  seed,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [NIB_W-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef SBOX_DRV_UNMASK_EN
  output logic [NIB_W-1:0]   out_data,
`else
  output logic [SH_W-1:0]    out_sh,
`endif
  output logic               err,
  output logic               sbox_rst,
  output logic [NIB_W-1:0]   SI_s0,
  output logic [NIB_W-1:0]   SI_s1,
  output logic [NIB_W-1:0]   SI_s2,
  output logic [NIB_W-1:0]   SI_s3,
  output logic [FRESH_W-1:0] Fresh,
  input  logic [NIB_W-1:0]   SO_s0,
  input  logic [NIB_W-1:0]   SO_s1,
  input  logic [NIB_W-1:0]   SO_s2,
  input  logic [NIB_W-1:0]   SO_s3,
  input  logic               Synch
);

  localparam int CNT_MAX_I = LATENCY + TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX_I + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_MAX_I);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt;
  logic [127:0]       prng_q;
  logic [SH_W-1:0]    res_sh;
  logic [NIB_W-1:0]   m1, m2, m3;
  logic               accept, cnt_hit, prng_unused;

  prng_xorshift128 u_prng (
    .clk     (clk),
    .rst     (rst),
    .seed    (seed),
    .state_o (prng_q)
  );

  // Mask nibbles come from the current PRNG word, i.e. the accept-cycle step.
  assign m1          = prng_q[FRESH_W        +: NIB_W];
  assign m2          = prng_q[FRESH_W+NIB_W  +: NIB_W];
  assign m3          = prng_q[FRESH_W+2*NIB_W +: NIB_W];
  assign prng_unused = ^prng_q[127:FRESH_W+3*NIB_W];
  assign accept      = in_valid & in_ready;
  assign cnt_hit     = (cnt == CNT_MAX);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state: Synch wins over timeout when both land on the same cycle.
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (accept)         state_n = RUN;
      RUN:  if (Synch)          state_n = CAPT;
            else if (cnt_hit)   state_n = IDLE;
      CAPT:                     state_n = DONE;
      DONE: if (out_ready)      state_n = IDLE;
      default:                  state_n = IDLE;
    endcase
  end

  // Handshake and sbox control decoded from state; sbox kept running in CAPT
  // so its gated output registers hold while they are latched.
  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    sbox_rst  = (state == IDLE) || (state == DONE);
  end

  // Datapath: share generation, RUN counter, fresh stream, capture, sticky err.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      SI_s0  <= '0;
      SI_s1  <= '0;
      SI_s2  <= '0;
      SI_s3  <= '0;
      Fresh  <= '0;
      res_sh <= '0;
      err    <= 1'b0;
    end else begin
      Fresh <= prng_q[FRESH_W-1:0];
      if (accept) begin
        SI_s1 <= m1;
        SI_s2 <= m2;
        SI_s3 <= m3;
        SI_s0 <= in_data ^ m1 ^ m2 ^ m3;
        cnt   <= '0;
      end else if (state == RUN && !cnt_hit) begin
        cnt <= cnt + 1'b1;
      end
      if (state == RUN && !Synch && cnt_hit) err <= 1'b1;
      if (state == CAPT) res_sh <= {SO_s3, SO_s2, SO_s1, SO_s0};
    end
  end

`ifdef SBOX_DRV_UNMASK_EN
  assign out_data = res_sh[15:12] ^ res_sh[11:8] ^ res_sh[7:4] ^ res_sh[3:0];
`else
  assign out_sh = res_sh;
`endif

endmodule

// File: tb/tb_sbox_share_driver_d3.sv
// Bench for sbox_share_driver_d3 with a behavioural masked sbox stub.
// Expected results are pushed on accept and popped on completion.
module tb_sbox_share_driver_d3;
  import sbox_drv_pkg::*;

  localparam int LAT = 11;
  localparam int TMO = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] seed = 128'h1;
  logic         in_valid = 1'b0;
  logic [3:0]   in_data = 4'h0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, err, sbox_rst, Synch;
  logic [3:0]   SI_s0, SI_s1, SI_s2, SI_s3;
  logic [3:0]   SO_s0 = 4'h0, SO_s1 = 4'h0, SO_s2 = 4'h0, SO_s3 = 4'h0;
  logic [77:0]  Fresh;
  logic [3:0]   res;
  logic [7:0]   cnt_sb = 8'd0;
  logic         sb_dead = 1'b0;
  logic [3:0]   exp_q[$];
  int           checks = 0;
  int           errors = 0;

`ifdef SBOX_DRV_UNMASK_EN
  logic [3:0] out_data;
  assign res = out_data;
`else
  logic [15:0] out_sh;
  assign res = out_sh[15:12] ^ out_sh[11:8] ^ out_sh[7:4] ^ out_sh[3:0];
`endif

  always #5 clk = ~clk;

  sbox_share_driver_d3 #(.LATENCY(LAT), .TIMEOUT(TMO), .SEED_W(128)) dut (
    .clk(clk), .rst(rst), .seed(seed),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef SBOX_DRV_UNMASK_EN
    .out_data(out_data),
`else
    .out_sh(out_sh),
`endif
    .err(err), .sbox_rst(sbox_rst),
    .SI_s0(SI_s0), .SI_s1(SI_s1), .SI_s2(SI_s2), .SI_s3(SI_s3),
    .Fresh(Fresh),
    .SO_s0(SO_s0), .SO_s1(SO_s1), .SO_s2(SO_s2), .SO_s3(SO_s3),
    .Synch(Synch)
  );

  // Sbox stub: Synch LAT cycles after rst release, remasked outputs one cycle later.
  assign Synch = !sb_dead && !sbox_rst && (cnt_sb == 8'(LAT));
  always @(posedge clk) begin
    logic [3:0] y;
    if (sbox_rst) cnt_sb <= 8'd0;
    else if (cnt_sb != 8'hFF) cnt_sb <= cnt_sb + 8'd1;
    if (!sbox_rst && cnt_sb == 8'(LAT)) begin
      y = SKINNY_SBOX[SI_s0 ^ SI_s1 ^ SI_s2 ^ SI_s3];
      SO_s1 <= SI_s2;
      SO_s2 <= SI_s3;
      SO_s3 <= SI_s1 ^ SI_s2;
      SO_s0 <= y ^ SI_s2 ^ SI_s3 ^ SI_s1 ^ SI_s2;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  task automatic do_reset(input logic [127:0] s);
    seed = s;
    rst  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Drives one nibble; reports latency, result and the shares seen after accept.
  task automatic run_txn(input logic [3:0] d, input bit complete, output int lat,
                         output bit got, output logic [3:0] obs, output logic [15:0] si);
    int w = 0;
    lat = 0; got = 0; obs = 4'h0; si = 16'h0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_wait: got in_ready=0 want 1 within 50 cycles");
      return;
    end
    in_valid = 1'b1; in_data = d;
    exp_q.push_back(SKINNY_SBOX[d]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    si = {SI_s3, SI_s2, SI_s1, SI_s0};
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    got = out_valid;
    obs = res;
    if (got && complete) begin
      out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; seed = 128'h1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, err, sbox_rst} !== 4'b0001 || res !== 4'h0 ||
        {SI_s3, SI_s2, SI_s1, SI_s0} !== 16'h0 || Fresh !== 78'h0) begin
      errors++;
      $display("FAIL reset: got rdy/vld/err/srst=%b res=%h si=%h fresh=%h want 0001 0 0000 0",
               {in_ready, out_valid, err, sbox_rst}, res, {SI_s3, SI_s2, SI_s1, SI_s0}, Fresh);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release: got in_ready=%b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int lat; bit got; logic [3:0] obs, e; logic [15:0] si;
    do_reset(128'h1);
    run_txn(4'h0, 1, lat, got, obs, si);
    e = exp_q.pop_front();
    checks++;
    if (!got || lat !== LAT + 2) begin
      errors++; $display("FAIL basic_latency: got %0d (valid=%0d) want %0d", lat, got, LAT + 2);
    end
    checks++;
    if (obs !== e || e !== 4'hC) begin
      errors++; $display("FAIL basic_result: got %h want %h", obs, 4'hC);
    end
    checks++;
    if (err !== 1'b0 || (si[15:12] ^ si[11:8] ^ si[7:4] ^ si[3:0]) !== 4'h0) begin
      errors++; $display("FAIL basic_err_shares: got err=%b si=%h want err=0 xor=0", err, si);
    end
  endtask

  task automatic test_sweep();
    int lat; bit got; logic [3:0] obs, e; logic [15:0] si;
    out_ready = 1'b0;
    for (int d = 0; d < 16; d++) begin
      run_txn(4'(d), 1, lat, got, obs, si);
      e = exp_q.pop_front();
      checks++;
      if (!got || obs !== e) begin
        errors++; $display("FAIL sweep_%0d: got %h (valid=%0d) want %h", d, obs, got, e);
      end
      checks++;
      if ((si[15:12] ^ si[11:8] ^ si[7:4] ^ si[3:0]) !== 4'(d)) begin
        errors++; $display("FAIL sweep_shares_%0d: got si=%h want xor %h", d, si, 4'(d));
      end
    end
  endtask

  task automatic test_back_pressure();
    int lat; bit got; logic [3:0] obs, e; logic [15:0] si;
    bit bad = 0;
    run_txn(4'h9, 0, lat, got, obs, si);
    e = exp_q.pop_front();
    checks++;
    if (!got || obs !== e) begin
      errors++; $display("FAIL bp_result: got %h (valid=%0d) want %h", obs, got, e);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || res !== e || in_ready !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL bp_hold: got vld=%b res=%h rdy=%b want 1 %h 0", out_valid, res, in_ready, e);
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_timeout();
    int lat; bit got; bit saw_vld = 0; logic [3:0] obs, e; logic [15:0] si;
    sb_dead = 1'b1;
    in_valid = 1'b1; in_data = 4'h2;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= LAT + TMO + 1; k++) begin
      if (out_valid) saw_vld = 1;
      if (k == LAT + TMO) begin
        checks++;
        if (err !== 1'b0 || in_ready !== 1'b0) begin
          errors++; $display("FAIL timeout_early: got err=%b rdy=%b want 0 0", err, in_ready);
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (err !== 1'b1 || in_ready !== 1'b1 || saw_vld || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout_flag: got err=%b rdy=%b vld_seen=%0d want 1 1 0", err, in_ready, saw_vld);
    end
    sb_dead = 1'b0;
    run_txn(4'hB, 1, lat, got, obs, si);
    e = exp_q.pop_front();
    checks++;
    if (!got || obs !== e || err !== 1'b1) begin
      errors++; $display("FAIL timeout_sticky: got res=%h err=%b want %h 1", obs, err, e);
    end
  endtask

  task automatic test_rst_mid_run();
    bit saw_vld = 0;
    in_valid = 1'b1; in_data = 4'h6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (sbox_rst !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0 ||
        {SI_s3, SI_s2, SI_s1, SI_s0} !== 16'h0 || Fresh !== 78'h0) begin
      errors++;
      $display("FAIL rst_mid_run: got srst=%b rdy=%b vld=%b err=%b si=%h want 1 0 0 0 0",
               sbox_rst, in_ready, out_valid, err, {SI_s3, SI_s2, SI_s1, SI_s0});
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL rst_hold_ready: got %b want 0", in_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_release_ready: got %b want 1", in_ready);
    end
    repeat (30) begin @(posedge clk); #1; if (out_valid) saw_vld = 1; end
    checks++;
    if (saw_vld) begin
      errors++; $display("FAIL rst_no_output: got out_valid=1 want 0");
    end
  endtask

  task automatic test_fresh_masks();
    int lat, same = 0; bit got; logic [3:0] obs, e; logic [15:0] si_a, si_b;
    logic [77:0] prev;
    do_reset(128'h0123456789ABCDEF_FEDCBA9876543210);
    in_valid = 1'b1; in_data = 4'h3;
    exp_q.push_back(SKINNY_SBOX[4'h3]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    si_a = {SI_s3, SI_s2, SI_s1, SI_s0};
    prev = Fresh;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (Fresh === prev) same++;
      prev = Fresh;
    end
    lat = 0;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    obs = res;
    e = exp_q.pop_front();
    checks++;
    if (same != 0) begin
      errors++; $display("FAIL fresh_changes: got %0d repeats want 0", same);
    end
    checks++;
    if (!out_valid || obs !== e || e !== 4'h0) begin
      errors++; $display("FAIL seed_a_result: got %h want %h", obs, 4'h0);
    end
    out_ready = 1'b1; @(posedge clk); #1; out_ready = 1'b0;
    do_reset(128'hDEADBEEF_0BADF00D_C0FFEE11_5EED5EED);
    run_txn(4'h3, 1, lat, got, obs, si_b);
    e = exp_q.pop_front();
    checks++;
    if (!got || obs !== e) begin
      errors++; $display("FAIL seed_b_result: got %h want %h", obs, e);
    end
    checks++;
    if (si_a === si_b) begin
      errors++; $display("FAIL seed_shares_differ: got %h and %h want different", si_a, si_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sweep();
    test_back_pressure();
    test_timeout();
    test_rst_mid_run();
    test_fresh_masks();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
